// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: fetch entry/state types, bubble word, opcodes.
// IF_FETCH_BUF_EN selects a 2-deep fetch pipeline; otherwise a single slot is used.
package riscv_pkg;

`ifdef IF_FETCH_BUF_EN
    localparam int FETCH_DEPTH = 2;
`else
    localparam int FETCH_DEPTH = 1;
`endif

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic {RUN, DRAIN} fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_fifo.sv
// Small FIFO of fetch entries; used both as the response buffer and the in-flight PC queue.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t din_i,
    output fetch_entry_t dout_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [2**PW];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop_i && (cnt_q != '0);
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= nxt(wr_q);
            end
            if (do_pop) rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/if_fetch_stage.sv
// RV32 instruction-fetch stage: PC generation, imem requests, response buffering, IF/ID register.
// Build option IF_FETCH_BUF_EN: 2 outstanding requests and 2-entry buffer instead of 1.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               pc_control,
    input  logic               IF_flush,
    input  logic [31:0]        br_target,
    if_fetch_stage_if.master   imem,
    output logic [31:0]        IF_ID_inst,
    output logic [31:0]        IF_ID_pc,
    output logic               IF_ID_valid
);
    import riscv_pkg::*;

    localparam int DEPTH = FETCH_DEPTH;
    localparam int CW    = $clog2(DEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [CW-1:0] kill_q, kill_d, out_q, out_d, buf_cnt;
    logic [CW:0]   inflight;
    logic          req_hold_q, req_hold_d;
    logic [31:0]   inst_q, inst_d, pc_q, pc_d;
    logic          valid_q, valid_d;
    logic          redirect, rsp, accept, drop, bypass, buf_push, buf_pop, credit, req, grant;
    fetch_entry_t  pcq_head, buf_head;
    logic          unused_bits;

    assign redirect = (pc_control || IF_flush) && !stall;
    assign rsp      = imem.imem_rvalid && (out_q != '0);
    assign drop     = rsp && (state_q == DRAIN);
    assign accept   = rsp && (state_q == RUN);
    assign buf_pop  = (buf_cnt != '0) && !stall && !redirect;
    assign bypass   = accept && (buf_cnt == '0) && !stall && !redirect;
    assign buf_push = accept && !bypass && !redirect;

    // out_q counts every in-flight request, killed ones included, so credit never over-issues.
    assign inflight = {1'b0, out_q} + {1'b0, buf_cnt};
    assign credit   = (inflight < (CW + 1)'(DEPTH)) || buf_pop;
    // A request left ungranted is held so addr/req stay stable even if the pop-credit vanishes.
    assign req      = !rst && !redirect && (req_hold_q || credit);
    assign grant    = req && imem.imem_gnt;
    assign out_d    = out_q + CW'(grant) - CW'(rsp);

    assign imem.imem_req  = req;
    assign imem.imem_addr = fpc_q;
    assign unused_bits    = ^{br_target[1:0], pcq_head.inst};

    fetch_fifo #(.DEPTH(DEPTH)) u_pcq (
        .clk(clk), .rst(rst), .clear_i(1'b0),
        .push_i(grant), .pop_i(rsp),
        .din_i('{pc: fpc_q, inst: 32'h0}),
        .dout_o(pcq_head), .count_o(out_q)
    );

    fetch_fifo #(.DEPTH(DEPTH)) u_buf (
        .clk(clk), .rst(rst), .clear_i(redirect),
        .push_i(buf_push), .pop_i(buf_pop),
        .din_i('{pc: pcq_head.pc, inst: imem.imem_rdata}),
        .dout_o(buf_head), .count_o(buf_cnt)
    );

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        case (state_q)
            RUN: begin
                if (redirect && out_d != '0) begin
                    kill_d  = out_d;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect)  kill_d = out_d;
                else if (drop) kill_d = kill_q - CW'(1);
                if (kill_d == '0) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        fpc_d      = fpc_q;
        req_hold_d = req && !imem.imem_gnt;
        inst_d     = inst_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        if (redirect)   fpc_d = {br_target[31:2], 2'b00};
        else if (grant) fpc_d = fpc_q + 32'd4;
        if (!stall) begin
            if (redirect) begin
                inst_d  = NOP_INST;
                valid_d = 1'b0;
            end else if (buf_pop) begin
                inst_d  = buf_head.inst;
                pc_d    = buf_head.pc;
                valid_d = 1'b1;
            end else if (bypass) begin
                inst_d  = imem.imem_rdata;
                pc_d    = pcq_head.pc;
                valid_d = 1'b1;
            end else begin
                inst_d  = NOP_INST;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            kill_q     <= '0;
            fpc_q      <= {RESET_PC[31:2], 2'b00};
            req_hold_q <= 1'b0;
            inst_q     <= NOP_INST;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            fpc_q      <= fpc_d;
            req_hold_q <= req_hold_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    assign IF_ID_inst  = inst_q;
    assign IF_ID_pc    = pc_q;
    assign IF_ID_valid = valid_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; imem returns addr ^ KEY with 1- or 2-cycle latency.
module tb_if_fetch_stage;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic clk = 1'b0, rst = 1'b1, stall = 1'b0, pc_control = 1'b0, IF_flush = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic gnt = 1'b1, lat2 = 1'b0;
    logic [31:0] inst, pc, inst2, pc2;
    logic valid, valid2;
    logic r1, r2, rw;
    logic [31:0] a1, a2, aw;
    int vecs = 0, errs = 0;

    if_fetch_stage_if mi();
    if_fetch_stage_if mw();

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .pc_control(pc_control), .IF_flush(IF_flush),
        .br_target(br_target), .imem(mi), .IF_ID_inst(inst), .IF_ID_pc(pc), .IF_ID_valid(valid)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst), .stall(1'b0), .pc_control(1'b0), .IF_flush(1'b0),
        .br_target(32'h0), .imem(mw), .IF_ID_inst(inst2), .IF_ID_pc(pc2), .IF_ID_valid(valid2)
    );

    always @(posedge clk) begin
        if (rst) begin
            r1 <= 1'b0; r2 <= 1'b0; rw <= 1'b0;
        end else begin
            r1 <= mi.imem_req && mi.imem_gnt;
            r2 <= r1 && lat2;
            rw <= mw.imem_req && mw.imem_gnt;
        end
        a1 <= mi.imem_addr; a2 <= a1; aw <= mw.imem_addr;
    end

    assign mi.imem_gnt    = gnt;
    assign mi.imem_rvalid = lat2 ? r2 : r1;
    assign mi.imem_rdata  = (lat2 ? a2 : a1) ^ KEY;
    assign mw.imem_gnt    = 1'b1;
    assign mw.imem_rvalid = rw;
    assign mw.imem_rdata  = aw ^ KEY;

    task automatic wait_valid(output logic [31:0] p, output logic [31:0] i, output bit ok);
        ok = 1'b0; p = '0; i = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (valid) begin
                ok = 1'b1; p = pc; i = inst;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vecs++; if (valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", valid); end
        vecs++; if (inst !== 32'h13) begin errs++; $display("FAIL reset_inst got=%h exp=00000013", inst); end
        vecs++; if (pc !== 32'h0) begin errs++; $display("FAIL reset_pc got=%h exp=00000000", pc); end
        vecs++; if (mi.imem_req !== 1'b0) begin errs++; $display("FAIL reset_req got=%b exp=0", mi.imem_req); end
        vecs++; if (pc2 !== 32'hFFFF_FFF8) begin errs++; $display("FAIL reset_pc_w got=%h exp=fffffff8", pc2); end
        vecs++; if (valid2 !== 1'b0) begin errs++; $display("FAIL reset_valid_w got=%b exp=0", valid2); end
    endtask

    task automatic test_sequential;
        logic ev[3];
        logic [31:0] ep[3];
        ev[0] = 1'b0; ep[0] = 32'h0;
        ev[1] = 1'b1; ep[1] = 32'h0;
`ifdef IF_FETCH_BUF_EN
        ev[2] = 1'b1; ep[2] = 32'h4;
`else
        ev[2] = 1'b0; ep[2] = 32'h0;
`endif
        rst = 1'b0;
        #1;
        vecs++; if (mi.imem_req !== 1'b1 || mi.imem_addr !== 32'h0) begin
            errs++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=00000000", mi.imem_req, mi.imem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vecs++; if (valid !== ev[k]) begin errs++; $display("FAIL seq_valid[%0d] got=%b exp=%b", k, valid, ev[k]); end
            if (ev[k]) begin
                vecs++; if (pc !== ep[k] || inst !== (ep[k] ^ KEY)) begin
                    errs++; $display("FAIL seq_pc[%0d] got pc=%h inst=%h exp pc=%h", k, pc, inst, ep[k]);
                end
            end
        end
    endtask

    task automatic test_stall;
        bit found = 1'b0, ok;
        logic [31:0] p, i;
        for (int k = 0; k < 20; k++) begin
            if (valid && pc == 32'h8) begin found = 1'b1; break; end
            @(negedge clk);
        end
        vecs++; if (!found) begin errs++; $display("FAIL stall_reach got=timeout exp=pc 00000008"); end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vecs++; if (pc !== 32'h8 || valid !== 1'b1 || inst !== 32'h5A5A_0008) begin
                errs++; $display("FAIL stall_hold[%0d] got pc=%h v=%b inst=%h exp pc=00000008 v=1", k, pc, valid, inst);
            end
        end
        stall = 1'b0;
        wait_valid(p, i, ok);
        vecs++; if (!ok || p !== 32'hC || i !== 32'h5A5A_000C) begin
            errs++; $display("FAIL stall_next0 got ok=%b pc=%h inst=%h exp pc=0000000c", ok, p, i);
        end
        wait_valid(p, i, ok);
        vecs++; if (!ok || p !== 32'h10 || i !== 32'h5A5A_0010) begin
            errs++; $display("FAIL stall_next1 got ok=%b pc=%h inst=%h exp pc=00000010", ok, p, i);
        end
    endtask

    task automatic test_backpressure;
        bit found = 1'b0, ok;
        logic [31:0] p, i;
        for (int k = 0; k < 30; k++) begin
            if (mi.imem_req && mi.imem_addr == 32'h20) begin found = 1'b1; break; end
            @(negedge clk);
        end
        vecs++; if (!found) begin errs++; $display("FAIL bp_reach got=timeout exp=req addr 00000020"); end
        gnt = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            vecs++; if (mi.imem_req !== 1'b1 || mi.imem_addr !== 32'h20) begin
                errs++; $display("FAIL bp_hold[%0d] got req=%b addr=%h exp req=1 addr=00000020", k, mi.imem_req, mi.imem_addr);
            end
            if (k >= 3) begin
                vecs++; if (valid !== 1'b0 || inst !== 32'h13) begin
                    errs++; $display("FAIL bp_bubble[%0d] got v=%b inst=%h exp v=0 inst=00000013", k, valid, inst);
                end
            end
        end
        gnt = 1'b1;
        wait_valid(p, i, ok);
        vecs++; if (!ok || p !== 32'h20 || i !== 32'h5A5A_0020) begin
            errs++; $display("FAIL bp_resume got ok=%b pc=%h inst=%h exp pc=00000020", ok, p, i);
        end
    endtask

    task automatic test_stall_vs_redirect;
        bit ok;
        logic [31:0] p, i, p2, i2;
        wait_valid(p, i, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL svr_reach got=timeout exp=valid"); end
        stall = 1'b1; pc_control = 1'b1; IF_flush = 1'b1; br_target = 32'h200;
        @(negedge clk);
        vecs++; if (pc !== p || valid !== 1'b1 || inst !== i) begin
            errs++; $display("FAIL svr_hold got pc=%h v=%b exp pc=%h v=1", pc, valid, p);
        end
        stall = 1'b0; pc_control = 1'b0; IF_flush = 1'b0;
        wait_valid(p2, i2, ok);
        vecs++; if (!ok || p2 !== p + 32'd4 || i2 !== ((p + 32'd4) ^ KEY)) begin
            errs++; $display("FAIL svr_next got ok=%b pc=%h exp pc=%h", ok, p2, p + 32'd4);
        end
    endtask

    task automatic test_redirect;
        bit found = 1'b0, ok;
        logic [31:0] p, i;
        gnt = 1'b0;
        repeat (3) @(negedge clk);
        lat2 = 1'b1; gnt = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (r1) begin found = 1'b1; break; end
        end
        vecs++; if (!found) begin errs++; $display("FAIL redir_reach got=timeout exp=request in flight"); end
        pc_control = 1'b1; IF_flush = 1'b1; br_target = 32'h100;
        #1;
        vecs++; if (mi.imem_req !== 1'b0) begin errs++; $display("FAIL redir_req got=%b exp=0", mi.imem_req); end
        @(negedge clk);
        vecs++; if (valid !== 1'b0 || inst !== 32'h13) begin
            errs++; $display("FAIL redir_bubble got v=%b inst=%h exp v=0 inst=00000013", valid, inst);
        end
        pc_control = 1'b0; IF_flush = 1'b0;
        wait_valid(p, i, ok);
        vecs++; if (!ok || p !== 32'h100 || i !== 32'h5A5A_0100) begin
            errs++; $display("FAIL redir_target got ok=%b pc=%h inst=%h exp pc=00000100", ok, p, i);
        end
        wait_valid(p, i, ok);
        vecs++; if (!ok || p !== 32'h104 || i !== 32'h5A5A_0104) begin
            errs++; $display("FAIL redir_next got ok=%b pc=%h inst=%h exp pc=00000104", ok, p, i);
        end
        gnt = 1'b0;
        repeat (3) @(negedge clk);
        lat2 = 1'b0; gnt = 1'b1;
    endtask

    task automatic test_wrap;
        logic [31:0] wp[3], wi[3];
        logic [31:0] first_pc = 32'hDEAD_BEEF;
        int nw = 0;
        bit got1 = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vecs++; if (valid !== 1'b0 || pc !== 32'h0 || inst !== 32'h13 || mi.imem_req !== 1'b0) begin
            errs++; $display("FAIL rerst_state got v=%b pc=%h inst=%h req=%b exp v=0 pc=0 inst=13 req=0", valid, pc, inst, mi.imem_req);
        end
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (valid2 && nw < 3) begin wp[nw] = pc2; wi[nw] = inst2; nw++; end
            if (valid && !got1) begin got1 = 1'b1; first_pc = pc; end
        end
        vecs++; if (nw != 3) begin errs++; $display("FAIL wrap_count got=%0d exp=3", nw); end
        else begin
            vecs++; if (wp[0] !== 32'hFFFF_FFF8 || wi[0] !== 32'hA5A5_FFF8) begin
                errs++; $display("FAIL wrap0 got pc=%h inst=%h exp pc=fffffff8 inst=a5a5fff8", wp[0], wi[0]);
            end
            vecs++; if (wp[1] !== 32'hFFFF_FFFC || wi[1] !== 32'hA5A5_FFFC) begin
                errs++; $display("FAIL wrap1 got pc=%h inst=%h exp pc=fffffffc inst=a5a5fffc", wp[1], wi[1]);
            end
            vecs++; if (wp[2] !== 32'h0 || wi[2] !== 32'h5A5A_0000) begin
                errs++; $display("FAIL wrap2 got pc=%h inst=%h exp pc=00000000 inst=5a5a0000", wp[2], wi[2]);
            end
        end
        vecs++; if (!got1 || first_pc !== 32'h0) begin
            errs++; $display("FAIL rerst_first got ok=%b pc=%h exp pc=00000000", got1, first_pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_backpressure();
        test_stall_vs_redirect();
        test_redirect();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
